// File: rtl/fifo_cmd_scheduler_if.sv
// Command FIFO read side and downstream issue port of the timed command scheduler.
// The scheduler takes the master modport; the FIFO/output stage side takes slave.
interface fifo_cmd_scheduler_if #(
  parameter int TS_WIDTH      = 32,
  parameter int PAYLOAD_WIDTH = 16
);
  logic                              fifo_empty;
  logic [TS_WIDTH+PAYLOAD_WIDTH-1:0] fifo_dout;
  logic                              fifo_read;
  logic                              out_valid;
  logic [PAYLOAD_WIDTH-1:0]          out_data;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_read,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_read,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fifo_cmd_scheduler.sv
// Timed command sequencer: pops {timestamp, payload} words from the command FIFO
// and issues each payload once the run timer reaches its timestamp.
// The interface instance must use the same TS_WIDTH/PAYLOAD_WIDTH as this module.
module fifo_cmd_scheduler #(
  parameter int TS_WIDTH      = 32,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold_on_empty,
  fifo_cmd_scheduler_if.master bus,
  output logic                 running,
  output logic                 done,
  output logic                 late_err,
  output logic [TS_WIDTH-1:0]  timer,
  output logic [CNT_WIDTH-1:0] issued_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_DATA = 2'd2,
    ARMED     = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     read_cmd;
  logic                     load_cmd;
  logic                     issue;
  logic                     issue_late;
  logic                     finish;
  logic                     accept_start;
  logic [TS_WIDTH-1:0]      ts_reg;
  logic [PAYLOAD_WIDTH-1:0] pl_reg;
  logic [TS_WIDTH-1:0]      dout_ts;
  logic [PAYLOAD_WIDTH-1:0] dout_pl;
  logic                     out_valid_q;
  logic [PAYLOAD_WIDTH-1:0] out_data_q;

  assign dout_ts = bus.fifo_dout[TS_WIDTH+PAYLOAD_WIDTH-1:PAYLOAD_WIDTH];
  assign dout_pl = bus.fifo_dout[PAYLOAD_WIDTH-1:0];

  // Next-state and per-cycle strobes; stop overrides everything outside IDLE.
  always_comb begin
    state_next   = state;
    read_cmd     = 1'b0;
    load_cmd     = 1'b0;
    issue        = 1'b0;
    issue_late   = 1'b0;
    finish       = 1'b0;
    accept_start = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept_start = 1'b1;
          state_next   = FETCH;
        end
      end
      FETCH: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!bus.fifo_empty) begin
          read_cmd   = 1'b1;
          state_next = WAIT_DATA;
        end else if (!hold_on_empty) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DATA: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          load_cmd   = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (stop) begin
          state_next = IDLE;
        end else if (timer >= ts_reg) begin
          issue      = 1'b1;
          issue_late = (timer > ts_reg);
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Run timer: cleared when a run starts, counts every non-idle cycle, frozen in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              timer <= '0;
    else if (accept_start)   timer <= '0;
    else if (state != IDLE)  timer <= timer + TS_WIDTH'(1);
  end

  // Capture the popped command the cycle after the read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_reg <= '0;
      pl_reg <= '0;
    end else if (load_cmd) begin
      ts_reg <= dout_ts;
      pl_reg <= dout_pl;
    end
  end

  // Registered issue strobe, payload, end-of-sequence pulse and run statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      done         <= 1'b0;
      late_err     <= 1'b0;
      issued_count <= '0;
    end else begin
      out_valid_q <= issue;
      done        <= finish;
      if (issue) out_data_q <= pl_reg;
      if (accept_start) begin
        late_err     <= 1'b0;
        issued_count <= '0;
      end else if (issue) begin
        issued_count <= issued_count + CNT_WIDTH'(1);
        if (issue_late) late_err <= 1'b1;
      end
    end
  end

  assign running       = (state != IDLE);
  assign bus.fifo_read = read_cmd;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_cmd_scheduler.sv
// Self-checking bench for fifo_cmd_scheduler: a queue-based command FIFO, a
// timestamp-arithmetic reference model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_fifo_cmd_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        hold_on_empty;
  logic        running;
  logic        done;
  logic        late_err;
  logic [31:0] timer;
  logic [15:0] issued_count;

  logic        wr_en;
  logic [47:0] wr_data;
  logic [47:0] fifo_q[$];
  int          read_count;

  int tests_run;
  int tests_failed;
  bit check_en;

  fifo_cmd_scheduler_if #(.TS_WIDTH(32), .PAYLOAD_WIDTH(16)) bus ();

  fifo_cmd_scheduler #(.TS_WIDTH(32), .PAYLOAD_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .hold_on_empty(hold_on_empty),
    .bus          (bus.master),
    .running      (running),
    .done         (done),
    .late_err     (late_err),
    .timer        (timer),
    .issued_count (issued_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Command FIFO: registered data the cycle after a read, registered empty flag.
  always @(posedge clk or negedge reset) begin
    logic [47:0] word;
    if (!reset) begin
      fifo_q.delete();
      bus.fifo_empty <= 1'b1;
      bus.fifo_dout  <= '0;
    end else begin
      if (bus.fifo_read && fifo_q.size() != 0) begin
        word = fifo_q.pop_front();
        bus.fifo_dout <= word;
        read_count++;
      end
      if (wr_en) fifo_q.push_back(wr_data);
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Reference model: a popped command at fetch timer t with timestamp ts is issued
  // when the timer reaches max(t+2, ts)+1, and is late when ts < t+2.
  longint      m_timer;
  bit          m_run;
  bit          m_seeking;
  bit          m_have;
  longint      m_due;
  bit          m_cmd_late;
  logic [15:0] m_cmd_pl;
  bit          m_valid;
  bit          m_done;
  bit          m_late;
  logic [15:0] m_out_data;
  longint      m_count;
  logic [47:0] model_q[$];

  // Advance the reference model on each clock edge from the inputs seen at that edge.
  always @(posedge clk or negedge reset) begin
    longint      t;
    longint      ts;
    logic [47:0] cmd;
    if (!reset) begin
      m_timer = 0; m_run = 0; m_seeking = 0; m_have = 0; m_due = 0;
      m_cmd_late = 0; m_cmd_pl = '0; m_valid = 0; m_done = 0; m_late = 0;
      m_out_data = '0; m_count = 0;
      model_q.delete();
    end else begin
      m_valid = 0;
      m_done  = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_timer = 0; m_late = 0; m_count = 0;
          m_seeking = 1; m_have = 0;
        end
      end else begin
        t = m_timer;
        m_timer = t + 1;
        if (stop) begin
          m_run = 0; m_seeking = 0; m_have = 0;
        end else if (m_seeking) begin
          if (model_q.size() != 0) begin
            cmd = model_q.pop_front();
            ts = longint'(cmd[47:16]);
            m_cmd_pl   = cmd[15:0];
            m_due      = ((t + 2 > ts) ? t + 2 : ts) + 1;
            m_cmd_late = (ts < t + 2);
            m_seeking  = 0;
            m_have     = 1;
          end else if (!hold_on_empty) begin
            m_run = 0; m_seeking = 0; m_done = 1;
          end
        end else if (m_have && (t + 1 == m_due)) begin
          m_valid    = 1;
          m_out_data = m_cmd_pl;
          m_count    = (m_count + 1) % 65536;
          if (m_cmd_late) m_late = 1;
          m_have     = 0;
          m_seeking  = 1;
        end
      end
      if (wr_en) model_q.push_back(wr_data);
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Compare every DUT output against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("running",      longint'(running),       longint'(m_run));
      checkOutput("fifo_read",    longint'(bus.fifo_read),
                  longint'(m_run && m_seeking && model_q.size() != 0 && !stop));
      checkOutput("out_valid",    longint'(bus.out_valid), longint'(m_valid));
      checkOutput("out_data",     longint'(bus.out_data),  longint'(m_out_data));
      checkOutput("done",         longint'(done),          longint'(m_done));
      checkOutput("late_err",     longint'(late_err),      longint'(m_late));
      checkOutput("timer",        longint'(timer),         m_timer);
      checkOutput("issued_count", longint'(issued_count),  m_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit do_start, input bit do_stop);
    start = do_start;
    stop  = do_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pushEntry(input logic [31:0] ts, input logic [15:0] pl);
    wr_en   = 1'b1;
    wr_data = {ts, pl};
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic doReset();
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic waitFor(input bit want_done, input int max_cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (want_done ? done : bus.out_valid) seen = 1'b1;
    end
    if (!seen) checkOutput(name, longint'(want_done ? done : bus.out_valid), 1);
  endtask

  task automatic waitTimer(input longint value, input int max_cycles);
    for (int i = 0; i < max_cycles && m_timer != value; i++) tick();
    checkOutput("wait_timer", m_timer, value);
  endtask

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    tests_run = 0; tests_failed = 0; check_en = 0; read_count = 0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; hold_on_empty = 1'b0;
    wr_en = 1'b0; wr_data = '0;
    tick();
    check_en = 1;
    doReset();
    checkOutput("reset_running", longint'(running), 0);
    checkOutput("reset_timer",   longint'(timer),   0);

    // Two on-time commands, then natural end of sequence.
    pushEntry(32'd10, 16'hAAAA);
    pushEntry(32'd20, 16'h5555);
    applyStimulus(1, 0);
    waitFor(0, 40, "s1_valid1");
    checkOutput("s1_t1",    longint'(timer),        11);
    checkOutput("s1_d1",    longint'(bus.out_data), 16'hAAAA);
    waitFor(0, 40, "s1_valid2");
    checkOutput("s1_t2",    longint'(timer),        21);
    checkOutput("s1_d2",    longint'(bus.out_data), 16'h5555);
    waitFor(1, 10, "s1_done");
    checkOutput("s1_done_t", longint'(timer),        22);
    checkOutput("s1_count",  longint'(issued_count), 2);
    checkOutput("s1_late",   longint'(late_err),     0);

    // Tightly spaced timestamps issue every 3 cycles and flag lateness.
    doReset();
    pushEntry(32'd2, 16'h0001);
    pushEntry(32'd3, 16'h0002);
    pushEntry(32'd4, 16'h0003);
    applyStimulus(1, 0);
    waitFor(0, 20, "s2_valid1");
    checkOutput("s2_t1",    longint'(timer),    3);
    checkOutput("s2_late1", longint'(late_err), 0);
    waitFor(0, 20, "s2_valid2");
    checkOutput("s2_t2",    longint'(timer),    6);
    waitFor(0, 20, "s2_valid3");
    checkOutput("s2_t3",    longint'(timer),    9);
    checkOutput("s2_late3", longint'(late_err), 1);
    checkOutput("s2_count", longint'(issued_count), 3);
    waitFor(1, 10, "s2_done");

    // Hold on empty FIFO, command arrives mid-run.
    hold_on_empty = 1'b1;
    read_count = 0;
    applyStimulus(1, 0);
    waitTimer(30, 60);
    pushEntry(32'd50, 16'h1234);
    waitFor(0, 60, "s3_valid");
    checkOutput("s3_t",       longint'(timer),        51);
    checkOutput("s3_d",       longint'(bus.out_data), 16'h1234);
    checkOutput("s3_reads",   read_count,             1);
    checkOutput("s3_running", longint'(running),      1);
    applyStimulus(0, 1);
    hold_on_empty = 1'b0;

    // Stop while armed discards the popped command and freezes the timer.
    pushEntry(32'd100, 16'hBEEF);
    applyStimulus(1, 0);
    waitTimer(40, 60);
    applyStimulus(0, 1);
    checkOutput("s4_running", longint'(running), 0);
    checkOutput("s4_timer",   longint'(timer),   41);
    tick(); tick(); tick();
    checkOutput("s4_frozen",  longint'(timer),   41);
    checkOutput("s4_fifo",    fifo_q.size(),     0);
    checkOutput("s4_data",    longint'(bus.out_data), 16'h1234);

    // Asynchronous reset while armed.
    pushEntry(32'd100, 16'h7777);
    applyStimulus(1, 0);
    waitTimer(20, 40);
    reset = 1'b0;
    #1;
    checkOutput("s5_timer",   longint'(timer),        0);
    checkOutput("s5_running", longint'(running),      0);
    checkOutput("s5_data",    longint'(bus.out_data), 0);
    checkOutput("s5_read",    longint'(bus.fifo_read), 0);
    tick();
    reset = 1'b1;
    tick();
    pushEntry(32'd5, 16'h0055);
    applyStimulus(1, 0);
    waitFor(0, 20, "s5_valid");
    checkOutput("s5_t",    longint'(timer),    6);
    checkOutput("s5_late", longint'(late_err), 0);
    waitFor(1, 10, "s5_done");

    // Timestamp 0 issues late; next start clears late_err; start while running ignored.
    pushEntry(32'd0, 16'h00F0);
    applyStimulus(1, 0);
    waitFor(0, 20, "s6_valid");
    checkOutput("s6_t",    longint'(timer),    3);
    checkOutput("s6_late", longint'(late_err), 1);
    waitFor(1, 10, "s6_done");
    pushEntry(32'd30, 16'h0F0F);
    applyStimulus(1, 0);
    checkOutput("s6_clear", longint'(late_err), 0);
    waitTimer(10, 20);
    applyStimulus(1, 0);
    checkOutput("s6_ignored", longint'(timer), 11);
    waitFor(0, 40, "s6_valid2");
    checkOutput("s6_t2", longint'(timer), 31);
    waitFor(1, 10, "s6_done2");

    // Randomized traffic, checked cycle-by-cycle against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] ts;
      if (cyc == 1500) begin
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) hold_on_empty = ~hold_on_empty;
      if (model_q.size() < 12 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 4) == 0) ts = 32'($urandom_range(0, 5));
        else                           ts = 32'(m_timer) + 32'($urandom_range(0, 15));
        wr_en   = 1'b1;
        wr_data = {ts, 16'($urandom)};
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    start = 1'b0; wr_en = 1'b0;
    applyStimulus(0, 1);
    tick();
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
